bus_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 26 ++
 rtl/oam_dma_engine.sv | 90 +++++++++
 rtl/bus_arbiter.sv | 103 ++++++++++
 tb/tb_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared bus/DMA types and constants for the CPU memory system
//
// Contents:
//   dma_state_e      OAM DMA engine state (DmaIdle, DmaStart, DmaActive)
//   DMA_REG_ADDR     DMA source register address (FF46)
//   OAM_BASE         first byte of OAM in the CPU map
//   HIGH_PAGE_BASE   start of I/O + HRAM + IE page; always reachable by the CPU
//   dma_src_eff()    folds echo-RAM source pages back onto work RAM
package cpu_pkg;

  typedef enum logic [1:0] {
    DmaIdle   = 2'd0,
    DmaStart  = 2'd1,
    DmaActive = 2'd2
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam logic [15:0] HIGH_PAGE_BASE = 16'hFF00;

  // Source pages E0..FF mirror C0..DF, so the DMA reads the underlying RAM.
  function automatic logic [7:0] dma_src_eff(input logic [7:0] src);
    return (src >= 8'hE0) ? src - 8'h20 : src;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA sequencer: state machine, byte index and source page
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   t_cycle         T-cycle phase; all state commits when t_cycle == 3
//   reg_write       committed CPU write to the DMA source register
//   reg_wdata       data of that write (new source page)
//   stall           CPU owns the bus this M-cycle; DMA must not advance
//   bus_data_in     system bus read data, forwarded to OAM
//   src             current source page register (readable by the CPU)
//   dma_req         DMA wants the bus (state ACTIVE)
//   dma_addr        DMA read address {effective source page, index}
//   oam_addr/oam_write/oam_data   OAM write port
module oam_dma_engine
  import cpu_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic        reg_write,
  input  logic [7:0]  reg_wdata,
  input  logic        stall,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  src,
  output logic        dma_req,
  output logic [15:0] dma_addr,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_data
);

  localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

  dma_state_e state, state_next;
  logic [7:0] index;
  logic       commit;

  assign commit = (t_cycle == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DmaIdle;
    end else begin
      state <= state_next;
    end
  end

  // A source-register write restarts from any state, including mid-transfer.
  always_comb begin
    state_next = state;
    if (commit) begin
      if (reg_write) begin
        state_next = DmaStart;
      end else begin
        case (state)
          DmaStart:  state_next = DmaActive;
          DmaActive: if (!stall && index == LAST_INDEX) state_next = DmaIdle;
          default:   state_next = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= 8'd0;
      src   <= 8'd0;
    end else if (commit) begin
      if (reg_write) begin
        src <= reg_wdata;
      end
      if (reg_write || state == DmaStart) begin
        index <= 8'd0;
      end else if (state == DmaActive && !stall) begin
        index <= (index == LAST_INDEX) ? 8'd0 : index + 8'd1;
      end
    end
  end

  always_comb begin
    dma_req   = (state == DmaActive);
    dma_addr  = {dma_src_eff(src), index};
    oam_addr  = index;
    oam_write = dma_req && commit && !stall;
    oam_data  = dma_req ? bus_data_in : 8'h00;
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - system bus arbiter between the CPU and the OAM DMA engine
//
// Optional feature macro: OAM_DMA_BLOCK_EN
//   defined   - during DMA, CPU accesses below FF00 are dropped (reads return FF)
//   undefined - during DMA, such accesses take the bus and stall the DMA
//
// Ports:
//   clk, reset                       system clock, asynchronous active-high reset
//   t_cycle                          T-cycle phase from the CPU (commit at 3)
//   cpu_addr/cpu_enable/cpu_write/cpu_data_out   CPU request
//   cpu_data_in                      read data back to the CPU
//   bus_addr/bus_enable/bus_write/bus_data_out   system bus request
//   bus_data_in                      system bus read data
//   oam_addr/oam_write/oam_data      OAM write port
//   dma_active                       DMA transfer in progress
module bus_arbiter #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_data,
  output logic        dma_active
);

  import cpu_pkg::*;

  logic [7:0]  src;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        is_dma_reg;
  logic        reg_write;
  logic        cpu_blocked;
  logic        cpu_takes_bus;

  assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);
  assign reg_write  = cpu_enable && cpu_write && is_dma_reg && (t_cycle == 2'd3);

`ifdef OAM_DMA_BLOCK_EN
  assign cpu_blocked = dma_req && cpu_enable && (cpu_addr < HIGH_PAGE_BASE);
`else
  assign cpu_blocked = 1'b0;
`endif

  // Any CPU access that is not blocked owns the bus this M-cycle and stalls the DMA.
  assign cpu_takes_bus = cpu_enable && !cpu_blocked;
  assign dma_active    = dma_req;

  oam_dma_engine #(
    .DMA_LEN(DMA_LEN)
  ) u_engine (
    .clk        (clk),
    .reset      (reset),
    .t_cycle    (t_cycle),
    .reg_write  (reg_write),
    .reg_wdata  (cpu_data_out),
    .stall      (cpu_takes_bus),
    .bus_data_in(bus_data_in),
    .src        (src),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .oam_addr   (oam_addr),
    .oam_write  (oam_write),
    .oam_data   (oam_data)
  );

  // Writes to the source register are absorbed here and never reach the bus.
  always_comb begin
    bus_addr     = cpu_addr;
    bus_enable   = cpu_enable && !(cpu_write && is_dma_reg);
    bus_write    = cpu_write && !is_dma_reg;
    bus_data_out = cpu_data_out;
    if (dma_req && !cpu_takes_bus) begin
      bus_addr   = dma_addr;
      bus_enable = 1'b1;
      bus_write  = 1'b0;
    end
  end

  always_comb begin
    if (is_dma_reg) begin
      cpu_data_in = src;
    end else if (cpu_blocked) begin
      cpu_data_in = 8'hFF;
    end else begin
      cpu_data_in = bus_data_in;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a queue-based model
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  t_cycle = 2'd0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_enable = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_data_out = 8'h00;
  logic [7:0]  cpu_data_in;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in = 8'h00;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_data;
  logic        dma_active;

  bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .t_cycle     (t_cycle),
    .cpu_addr    (cpu_addr),
    .cpu_enable  (cpu_enable),
    .cpu_write   (cpu_write),
    .cpu_data_out(cpu_data_out),
    .cpu_data_in (cpu_data_in),
    .bus_addr    (bus_addr),
    .bus_enable  (bus_enable),
    .bus_write   (bus_write),
    .bus_data_out(bus_data_out),
    .bus_data_in (bus_data_in),
    .oam_addr    (oam_addr),
    .oam_write   (oam_write),
    .oam_data    (oam_data),
    .dma_active  (dma_active)
  );

`ifdef OAM_DMA_BLOCK_EN
  localparam bit BLOCK = 1'b1;
`else
  localparam bit BLOCK = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: remaining OAM indices to write, START delay, source page.
  int m_q[$];
  int m_delay = 0;
  int m_src = 0;

  int mc = 0;
  int n_writes = 0;
  int first_wr = -1;
  int last_wr = -1;

  logic [15:0] o_bus_addr;
  logic [7:0]  o_cpu_data_in;
  logic [7:0]  o_oam_addr;
  logic        o_oam_write;
  logic        o_dma_active;

  // t_cycle advances on the falling edge so it is stable at every rising edge.
  initial begin
    forever begin
      #5 clk = ~clk;
      if (!clk) t_cycle = t_cycle + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_phase(input logic [1:0] p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (t_cycle != p && n < 8);
  endtask

  task automatic clear_stats();
    n_writes = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  // One M-cycle: drive at phase 0, check at phase 3 before the commit edge, then advance the model.
  task automatic mcycle(input logic en, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] bdi);
    bit active, is_reg, reg_wr, blocked, dma_bus;
    int eff, idx, exp_rd;
    to_phase(2'd0);
    cpu_enable   = en;
    cpu_write    = wr;
    cpu_addr     = addr;
    cpu_data_out = wd;
    bus_data_in  = bdi;
    to_phase(2'd3);
    mc++;
    active  = (m_delay == 0) && (m_q.size() > 0);
    is_reg  = (addr == 16'hFF46);
    reg_wr  = en && wr && is_reg;
    blocked = BLOCK && active && en && (addr < 16'hFF00);
    dma_bus = active && !(en && !blocked);
    o_bus_addr    = bus_addr;
    o_cpu_data_in = cpu_data_in;
    o_oam_addr    = oam_addr;
    o_oam_write   = oam_write;
    o_dma_active  = dma_active;
    check("dma_active", 32'(dma_active), 32'(active));
    if (dma_bus) begin
      idx = m_q[0];
      eff = (m_src >= 224) ? m_src - 32 : m_src;
      check("bus_addr_dma", 32'(bus_addr), eff * 256 + idx);
      check("bus_enable_dma", 32'(bus_enable), 32'd1);
      check("bus_write_dma", 32'(bus_write), 32'd0);
      check("oam_write", 32'(oam_write), 32'd1);
      check("oam_addr", 32'(oam_addr), idx);
      check("oam_data", 32'(oam_data), 32'(bdi));
    end else begin
      check("bus_addr_cpu", 32'(bus_addr), 32'(addr));
      check("bus_enable_cpu", 32'(bus_enable), 32'(en && !reg_wr));
      check("oam_write_off", 32'(oam_write), 32'd0);
      if (en && wr && !is_reg) check("bus_wdata", 32'(bus_data_out), 32'(wd));
    end
    if (en && !wr) begin
      exp_rd = is_reg ? m_src : (blocked ? 255 : int'(bdi));
      check("cpu_rdata", 32'(cpu_data_in), exp_rd);
    end
    if (oam_write === 1'b1) begin
      n_writes++;
      if (first_wr < 0) first_wr = mc;
      last_wr = mc;
    end
    if (dma_bus) void'(m_q.pop_front());
    if (m_delay > 0) m_delay--;
    if (reg_wr) begin
      m_src = int'(wd);
      m_q.delete();
      for (int i = 0; i < 160; i++) m_q.push_back(i);
      m_delay = 1;
    end
  endtask

  task automatic idle();
    mcycle(1'b0, 1'b0, 16'($urandom), 8'h00, 8'($urandom));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_q.size() > 0 && guard < 600) begin
      idle();
      guard++;
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 16'hFEFF));
      1:       return 16'hFF00 + 16'($urandom_range(0, 255));
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n0, stalls, bad;
    logic [15:0] a;
    logic        w;

    // Reset state
    cpu_addr    = 16'h1234;
    bus_data_in = 8'h77;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_oam_write", 32'(oam_write), 32'd0);
    check("rst_oam_addr", 32'(oam_addr), 32'd0);
    check("rst_oam_data", 32'(oam_data), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'h1234);
    check("rst_cpu_rdata", 32'(cpu_data_in), 32'h77);
    reset = 1'b0;

    // Idle pass-through
    clear_stats();
    mcycle(1'b1, 1'b0, 16'hC123, 8'h00, 8'h5A);
    check("idle_bus_addr", 32'(o_bus_addr), 32'hC123);
    check("idle_rdata", 32'(o_cpu_data_in), 32'h5A);
    repeat (20) begin
      a = 16'($urandom);
      w = 1'($urandom);
      if (a == 16'hFF46) w = 1'b0;
      mcycle(1'($urandom), w, a, 8'($urandom), 8'($urandom));
    end
    check("idle_no_oam", n_writes, 0);

    // Full transfer from C000
    clear_stats();
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hC0, 8'($urandom));
    n0 = mc;
    repeat (170) idle();
    check("full_count", n_writes, 160);
    check("full_first", first_wr, n0 + 2);
    check("full_last", last_wr, n0 + 161);
    check("full_done", 32'(o_dma_active), 32'd0);
    mcycle(1'b1, 1'b0, 16'hFF46, 8'h00, 8'($urandom));
    check("ff46_readback", 32'(o_cpu_data_in), 32'hC0);

    // Echo source page
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hE1, 8'($urandom));
    idle();
    idle();
    check("echo_addr", 32'(o_bus_addr), 32'hC100);
    check("echo_index", 32'(o_oam_addr), 32'd0);
    drain();

    // CPU access mid-transfer
    clear_stats();
    mcycle(1'b1, 1'b1, 16'hFF46, 8'h80, 8'($urandom));
    n0 = mc;
    stalls = 0;
    repeat (10) idle();
    mcycle(1'b1, 1'b0, 16'h8000, 8'h00, 8'h3C);
    check("mid_read_data", 32'(o_cpu_data_in), BLOCK ? 32'hFF : 32'h3C);
    check("mid_read_oam", 32'(o_oam_write), BLOCK ? 32'd1 : 32'd0);
    stalls += BLOCK ? 0 : 1;
    mcycle(1'b1, 1'b1, 16'hFF80, 8'h55, 8'($urandom));
    check("hram_bus_addr", 32'(o_bus_addr), 32'hFF80);
    check("hram_stall", 32'(o_oam_write), 32'd0);
    stalls += 1;
    drain();
    check("mid_count", n_writes, 160);
    check("mid_last", last_wr, n0 + 161 + stalls);

    // Restart at index 50
    mcycle(1'b1, 1'b1, 16'hFF46, 8'h40, 8'($urandom));
    while (m_q.size() > 110) idle();
    mcycle(1'b1, 1'b1, 16'hFF46, 8'hD0, 8'($urandom));
    idle();
    check("restart_start", 32'(o_dma_active), 32'd0);
    idle();
    check("restart_addr", 32'(o_bus_addr), 32'hD000);
    check("restart_index", 32'(o_oam_addr), 32'd0);
    check("restart_write", 32'(o_oam_write), 32'd1);
    drain();

    // Randomised traffic
    repeat (400) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        mcycle(1'b1, 1'b1, 16'hFF46, 8'($urandom), 8'($urandom));
      end else if (r < 25) begin
        a = pick_addr();
        w = 1'($urandom);
        if (a == 16'hFF46) w = 1'b0;
        mcycle(1'b1, w, a, 8'($urandom), 8'($urandom));
      end else begin
        idle();
      end
    end
    drain();

    // Reset mid-transfer at index 80
    mcycle(1'b1, 1'b1, 16'hFF46, 8'h9A, 8'($urandom));
    while (m_q.size() > 80) idle();
    to_phase(2'd1);
    check("pre_reset_active", 32'(dma_active), 32'd1);
    check("pre_reset_index", 32'(oam_addr), 32'd80);
    reset = 1'b1;
    #1;
    check("reset_dma_active", 32'(dma_active), 32'd0);
    check("reset_oam_write", 32'(oam_write), 32'd0);
    check("reset_oam_addr", 32'(oam_addr), 32'd0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (oam_write !== 1'b0 || dma_active !== 1'b0) bad++;
    end
    check("reset_hold", bad, 0);
    reset = 1'b0;
    m_q.delete();
    m_delay = 0;
    m_src = 0;
    clear_stats();
    mcycle(1'b1, 1'b0, 16'hFF46, 8'h00, 8'($urandom));
    check("ff46_after_reset", 32'(o_cpu_data_in), 32'h00);
    repeat (5) idle();
    check("after_reset_no_oam", n_writes, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
